// File: rtl/yabot_pkg.sv
// Shared definitions for the yabot sonar path.
// Result word layout, scheduler state codes and the width sentinel.
package yabot_pkg;

    localparam logic [3:0] ID_SONARS = 4'd1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SELECT    = 3'd1;
    localparam logic [2:0] ST_TRIG      = 3'd2;
    localparam logic [2:0] ST_WAIT_RISE = 3'd3;
    localparam logic [2:0] ST_MEASURE   = 3'd4;
    localparam logic [2:0] ST_REPORT    = 3'd5;
    localparam logic [2:0] ST_GAP       = 3'd6;

    localparam int RW_ID_LSB  = 28;
    localparam int RW_CH_LSB  = 24;
    localparam int RW_TO_BIT  = 23;
    localparam int RW_SEQ_LSB = 16;
    localparam int RW_W_LSB   = 0;

    localparam logic [15:0] WIDTH_SENTINEL = 16'hFFFF;

    function automatic logic [31:0] pack_res(
        input logic [3:0]  ch,
        input logic        to,
        input logic [6:0]  seq,
        input logic [15:0] width
    );
        logic [31:0] w;
        w = '0;
        w[RW_ID_LSB +: 4]  = ID_SONARS;
        w[RW_CH_LSB +: 4]  = ch;
        w[RW_TO_BIT]       = to;
        w[RW_SEQ_LSB +: 7] = seq;
        w[RW_W_LSB +: 16]  = width;
        return w;
    endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Echo input conditioning: 2-FF synchronizer, registered edge pulses.
// Define SONAR_ECHO_FILT_EN to require 4 equal synced samples per level change.
module sonar_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_raw,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic lvl;

`ifdef SONAR_ECHO_FILT_EN
    logic       filt_q, filt_d;
    logic [1:0] fcnt_q, fcnt_d;

    // Accept a new level only after it has been seen 4 cycles in a row
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 2'd0;
        if (s2_q != filt_q) begin
            if (fcnt_q == 2'd3) begin
                filt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 2'd1;
            end
        end
    end

    // Filter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= 2'd0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    // Edge detect on the conditioned level
    always_comb begin
        prev_d = lvl;
        rise_d = lvl & ~prev_q;
        fall_d = ~lvl & prev_q;
    end

    // Synchronizer and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= echo_raw;
            s2_q   <= s1_q;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic sonar scheduler: trigger, time echo, emit result.
// One ping at a time; results leave through a valid/ready handshake.
module sonar_scheduler
    import yabot_pkg::*;
#(
    parameter int N_SONAR     = 6,
    parameter int US_DIV      = 50,
    parameter int TRIG_US     = 10,
    parameter int RISE_US     = 1000,
    parameter int ECHO_MAX_US = 30000,
    parameter int GAP_US      = 5000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_SONAR-1:0] chan_mask,
    output logic [N_SONAR-1:0] trig,
    input  logic [N_SONAR-1:0] echo,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_word
);

    localparam int DIV_W = $clog2(US_DIV + 1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         cur_ch_q, cur_ch_d;
    logic [3:0]         last_ch_q, last_ch_d;
    logic [6:0]         seq_q, seq_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_word_q, res_word_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [15:0]        us_cnt_q, us_cnt_d;

    logic [N_SONAR-1:0] rise_vec, fall_vec;
    logic [N_SONAR-1:0] ch_oh;
    logic               us_tick;
    logic               cur_rise, cur_fall;
    logic [31:0]        mask_ext;
    logic [3:0]         pick_ch;
    logic [4:0]         pick_idx;
    logic               pick_found;

    for (genvar g = 0; g < N_SONAR; g++) begin : g_echo
        sonar_echo_sync u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .echo_raw (echo[g]),
            .rise     (rise_vec[g]),
            .fall     (fall_vec[g])
        );
    end

    assign ch_oh    = {{(N_SONAR-1){1'b0}}, 1'b1} << cur_ch_q;
    assign cur_rise = |(rise_vec & ch_oh);
    assign cur_fall = |(fall_vec & ch_oh);
    assign us_tick  = (div_q == DIV_W'(US_DIV - 1));
    assign mask_ext = {{(32-N_SONAR){1'b0}}, chan_mask};

    // Next enabled channel strictly after last_ch, wrapping
    always_comb begin
        pick_ch    = last_ch_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= N_SONAR; i++) begin
            pick_idx = {1'b0, last_ch_q} + 5'(i);
            if (pick_idx >= 5'(N_SONAR)) begin
                pick_idx = pick_idx - 5'(N_SONAR);
            end
            if (!pick_found && mask_ext[pick_idx]) begin
                pick_ch    = pick_idx[3:0];
                pick_found = 1'b1;
            end
        end
    end

    // Ping sequencing and result capture
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        last_ch_d   = last_ch_q;
        seq_d       = seq_q;
        res_valid_d = res_valid_q;
        res_word_d  = res_word_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && (|chan_mask)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!enable || !(|chan_mask)) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_ch_d = pick_ch;
                    state_d  = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (us_tick && us_cnt_q == 16'(TRIG_US - 1)) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (cur_rise) begin
                    state_d = ST_MEASURE;
                end else if (us_cnt_q >= 16'(RISE_US)) begin
                    res_word_d  = pack_res(cur_ch_q, 1'b1, seq_q,
                                           WIDTH_SENTINEL);
                    res_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end
            end
            ST_MEASURE: begin
                if (cur_fall) begin
                    res_word_d  = pack_res(cur_ch_q, 1'b0, seq_q,
                                           us_cnt_q);
                    res_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end else if (us_cnt_q >= 16'(ECHO_MAX_US)) begin
                    res_word_d  = pack_res(cur_ch_q, 1'b1, seq_q,
                                           16'(ECHO_MAX_US));
                    res_valid_d = 1'b1;
                    state_d     = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    last_ch_d   = cur_ch_q;
                    seq_d       = seq_q + 7'd1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (us_tick && us_cnt_q == 16'(GAP_US - 1)) begin
                    state_d = ST_SELECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Microsecond timebase, restarted on every state entry
    always_comb begin
        div_d    = div_q;
        us_cnt_d = us_cnt_q;
        if (state_d != state_q) begin
            div_d    = '0;
            us_cnt_d = '0;
        end else if (us_tick) begin
            div_d = '0;
            if (us_cnt_q != 16'hFFFF) begin
                us_cnt_d = us_cnt_q + 16'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_ch_q    <= '0;
            last_ch_q   <= 4'(N_SONAR - 1);
            seq_q       <= '0;
            res_valid_q <= 1'b0;
            res_word_q  <= '0;
            div_q       <= '0;
            us_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            last_ch_q   <= last_ch_d;
            seq_q       <= seq_d;
            res_valid_q <= res_valid_d;
            res_word_q  <= res_word_d;
            div_q       <= div_d;
            us_cnt_q    <= us_cnt_d;
        end
    end

    assign trig      = (state_q == ST_TRIG) ? ch_oh : '0;
    assign res_valid = res_valid_q;
    assign res_word  = res_word_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Randomized bench for sonar_scheduler with a ping-level reference model.
// Timing parameters are scaled down so the run stays short.
module tb_sonar_scheduler;

    localparam int N      = 6;
    localparam int DIV    = 4;
    localparam int TRIG   = 10;
    localparam int RISE   = 100;
    localparam int EMAX   = 300;
    localparam int GAP    = 20;

    localparam int K_RAND   = 0;
    localparam int K_FIX    = 1;
    localparam int K_NOECHO = 2;
    localparam int K_LONG   = 3;
    localparam int K_GLITCH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] chan_mask;
    logic [N-1:0] trig;
    logic [N-1:0] echo;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_word;

    int total = 0;
    int bad   = 0;

    int force_kind = K_RAND;
    int force_d    = 10;
    int force_w    = 58;
    logic stall    = 1'b0;

    int exp_to  [0:255];
    int exp_w   [0:255];
    int exp_tol [0:255];
    int n_exp   = 0;

    int          n_hs = 0;
    logic [31:0] last_word = '0;
    int          last_trig_len = 0;

    sonar_scheduler #(
        .N_SONAR     (N),
        .US_DIV      (DIV),
        .TRIG_US     (TRIG),
        .RISE_US     (RISE),
        .ECHO_MAX_US (EMAX),
        .GAP_US      (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .chan_mask (chan_mask),
        .trig      (trig),
        .echo      (echo),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_word  (res_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic ok,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // Consumer: random readiness, forced low while stalling
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = stall ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
    end

    // Echo responder: answers each completed trigger pulse
    initial begin
        logic [N-1:0] prev;
        logic [2:0]   ch;
        int kind, d, w, hold;
        echo = '0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev != 0 && trig == 0) begin
                ch   = 3'($clog2(prev));
                kind = force_kind;
                d    = $urandom_range(2, 60);
                w    = $urandom_range(2, 120);
                if (kind == K_RAND) begin
                    case ($urandom_range(0, 9))
                        0: kind = K_NOECHO;
                        1: kind = K_LONG;
                        2: kind = K_GLITCH;
                        default: kind = K_FIX;
                    endcase
                end else if (kind == K_FIX) begin
                    d = force_d;
                    w = force_w;
                end
                hold = w * DIV;
                case (kind)
                    K_NOECHO: begin
                        exp_to[n_exp] = 1; exp_w[n_exp] = 65535;
                        exp_tol[n_exp] = 0;
                    end
                    K_LONG: begin
                        hold = (EMAX + 20) * DIV;
                        exp_to[n_exp] = 1; exp_w[n_exp] = EMAX;
                        exp_tol[n_exp] = 0;
                    end
                    K_GLITCH: begin
                        hold = 2;
`ifdef SONAR_ECHO_FILT_EN
                        exp_to[n_exp] = 1; exp_w[n_exp] = 65535;
                        exp_tol[n_exp] = 0;
`else
                        exp_to[n_exp] = 0; exp_w[n_exp] = 0;
                        exp_tol[n_exp] = 1;
`endif
                    end
                    default: begin
                        exp_to[n_exp] = 0; exp_w[n_exp] = w;
                        exp_tol[n_exp] = 1;
                    end
                endcase
                n_exp++;
                if (kind != K_NOECHO) begin
                    repeat (d * DIV) @(negedge clk);
                    echo[ch] = 1'b1;
                    repeat (hold) @(negedge clk);
                    echo[ch] = 1'b0;
                end
            end
            prev = trig;
        end
    end

    // Compare process: checks DUT outputs against the ping model each cycle
    initial begin
        logic [N-1:0] ptrig;
        logic         pvalid, pready;
        logic [31:0]  pword;
        int cyc, hs_cyc, tlen, pred, mlast, mseq, diff, idx;
        logic found;
        ptrig = '0; pvalid = 0; pready = 0; pword = '0;
        cyc = 0; hs_cyc = -100000; tlen = 0; pred = 0;
        mlast = N - 1; mseq = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mlast = N - 1; mseq = 0; tlen = 0;
                hs_cyc = -100000;
                ptrig = '0; pvalid = 0; pready = 0;
            end else begin
                check("trig_onehot", $onehot0(trig), 32'(trig), 0);
                if (ptrig == 0 && trig != 0) begin
                    found = 0;
                    for (int j = 1; j <= N; j++) begin
                        idx = (mlast + j) % N;
                        if (!found && ((chan_mask >> idx) & 1) != 0) begin
                            pred = idx; found = 1;
                        end
                    end
                    check("trig_ch", trig == N'(1 << pred),
                          32'(trig), 32'(1 << pred));
                    check("gap_len", (cyc - hs_cyc) >= GAP * DIV,
                          32'(cyc - hs_cyc), 32'(GAP * DIV));
                    tlen = 1;
                end else if (trig != 0) begin
                    tlen++;
                end else if (ptrig != 0) begin
                    check("trig_len", tlen == TRIG * DIV,
                          32'(tlen), 32'(TRIG * DIV));
                    last_trig_len = tlen;
                end
                if (res_valid) begin
                    check("quiet_in_report", trig == 0, 32'(trig), 0);
                end
                if (pvalid && !pready) begin
                    check("hold_stable",
                          res_valid && res_word == pword,
                          res_word, pword);
                end
                if (res_valid && res_ready) begin
                    if (n_hs < n_exp) begin
                        check("word_hdr",
                              res_word[31:16] == {4'h1, 4'(pred),
                                  1'(exp_to[n_hs]), 7'(mseq)},
                              32'(res_word[31:16]),
                              32'({4'h1, 4'(pred), 1'(exp_to[n_hs]),
                                   7'(mseq)}));
                        diff = int'(res_word[15:0]) - exp_w[n_hs];
                        if (diff < 0) diff = -diff;
                        check("word_width", diff <= exp_tol[n_hs],
                              32'(res_word[15:0]), 32'(exp_w[n_hs]));
                    end else begin
                        check("unexpected_result", 1'b0, res_word, 0);
                    end
                    last_word = res_word;
                    mlast = pred;
                    mseq = (mseq + 1) % 128;
                    hs_cyc = cyc;
                    n_hs++;
                end
                ptrig = trig; pvalid = res_valid;
                pready = res_ready; pword = res_word;
            end
        end
    end

    task automatic wait_hs(input int target, input string nm);
        int c;
        c = 0;
        while (n_hs < target && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check(nm, n_hs >= target, 32'(n_hs), 32'(target));
    endtask

    // Main sequence
    initial begin
        logic ok;
        int c, base;
        rst_n = 1'b0;
        enable = 1'b0;
        chan_mask = 6'h3F;
        repeat (5) @(negedge clk);
        check("rst_trig", trig == 0, 32'(trig), 0);
        check("rst_valid", res_valid == 0, 32'(res_valid), 0);
        check("rst_word", res_word == 0, res_word, 0);
        rst_n = 1'b1;

        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (trig != 0 || res_valid) ok = 1'b0;
        end
        check("disabled_quiet", ok, 32'(ok), 1);

        enable = 1'b1;
        c = 0;
        while (trig == 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("first_trig", trig != 0, 32'(trig), 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_trig", trig == 0, 32'(trig), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (res_valid || trig != 0) ok = 1'b0;
        end
        check("no_partial", ok, 32'(ok), 1);

        chan_mask = 6'b000001;
        force_kind = K_FIX;
        force_d = 10;
        force_w = 58;
        enable = 1'b1;
        wait_hs(1, "dir_done");
        check("dir_hdr", last_word[31:16] == 16'h1000,
              32'(last_word[31:16]), 32'h1000);
        check("dir_width", last_word[15:0] >= 16'd57 &&
              last_word[15:0] <= 16'd59, 32'(last_word[15:0]), 32'd58);
        check("dir_trig_len", last_trig_len == 40, 32'(last_trig_len), 40);
        force_kind = K_RAND;
        wait_hs(2, "repeat_ch0");

        chan_mask = 6'b100101;
        wait_hs(6, "rr_three");

        chan_mask = 6'b001000;
        force_kind = K_NOECHO;
        wait_hs(7, "noecho_done");
        check("noecho_hdr", last_word[27:23] == 5'b00111,
              32'(last_word[27:23]), 32'h7);
        check("noecho_w", last_word[15:0] == 16'hFFFF,
              32'(last_word[15:0]), 32'hFFFF);
        force_kind = K_LONG;
        wait_hs(8, "long_done");
        check("long_to", last_word[23] == 1'b1, 32'(last_word[23]), 1);
        check("long_w", last_word[15:0] == 16'd300,
              32'(last_word[15:0]), 32'd300);
        force_kind = K_GLITCH;
        wait_hs(9, "glitch_done");
`ifdef SONAR_ECHO_FILT_EN
        check("glitch_w", last_word[15:0] == 16'hFFFF,
              32'(last_word[15:0]), 32'hFFFF);
`else
        check("glitch_w", last_word[15:0] <= 16'd1,
              32'(last_word[15:0]), 32'd0);
`endif

        force_kind = K_RAND;
        chan_mask = 6'h3F;
        stall = 1'b1;
        c = 0;
        while (!res_valid && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("stall_valid", res_valid, 32'(res_valid), 1);
        base = n_hs;
        repeat (1000) @(negedge clk);
        check("stall_no_xfer", n_hs == base, 32'(n_hs), 32'(base));
        check("stall_still_valid", res_valid, 32'(res_valid), 1);
        stall = 1'b0;
        wait_hs(base + 1, "stall_release");

        for (int k = 0; k < 25; k++) begin
            chan_mask = 6'($urandom_range(1, 63));
            wait_hs(n_hs + 1, "rand_ping");
        end

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
